// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and the per-edge action decode used by the PC and IF/ID registers.
// Optional build macro FETCH_ALIGN_CHECK_EN is consumed by fetch_stage and fetch_pc_reg.
package fetch_stage_pkg;

    localparam int unsigned FS_DATA_WIDTH   = 32;
    localparam logic [31:0] FS_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] FS_NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [2:0] {
        ACT_EXC   = 3'd0,
        ACT_BR    = 3'd1,
        ACT_FLUSH = 3'd2,
        ACT_STALL = 3'd3,
        ACT_FETCH = 3'd4,
        ACT_MISS  = 3'd5
    } fetch_act_e;

    // Exactly one action per edge; earlier arguments win.
    function automatic fetch_act_e fetch_action(
        input logic exc,
        input logic br,
        input logic fl,
        input logic st,
        input logic cv
    );
        if (exc)     return ACT_EXC;
        else if (br) return ACT_BR;
        else if (fl) return ACT_FLUSH;
        else if (st) return ACT_STALL;
        else if (cv) return ACT_FETCH;
        else         return ACT_MISS;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register (module fetch_pc_reg) with prioritised next-PC selection.
// With FETCH_ALIGN_CHECK_EN defined, redirect targets load with bits [1:0] cleared.
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH   = FS_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = DATA_WIDTH'(FS_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  fetch_act_e            i_act,
    input  logic [DATA_WIDTH-1:0] i_exc_target,
    input  logic [DATA_WIDTH-1:0] i_br_target,
    output logic [DATA_WIDTH-1:0] o_pc
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic [DATA_WIDTH-1:0] w_exc_target;
    logic [DATA_WIDTH-1:0] w_br_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_exc_target = {i_exc_target[DATA_WIDTH-1:2], 2'b00};
    assign w_br_target  = {i_br_target[DATA_WIDTH-1:2], 2'b00};
`else
    assign w_exc_target = i_exc_target;
    assign w_br_target  = i_br_target;
`endif

    always_comb begin
        w_next_pc = r_pc;
        case (i_act)
            ACT_EXC:   w_next_pc = w_exc_target;
            ACT_BR:    w_next_pc = w_br_target;
            ACT_FETCH: w_next_pc = r_pc + DATA_WIDTH'(4);
            default:   w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pc <= RESET_VECTOR;
        else        r_pc <= w_next_pc;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC drive to the I-cache and the IF/ID output register.
// Define FETCH_ALIGN_CHECK_EN to add fetch_misaligned_out and word-align redirect targets.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH   = FS_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = DATA_WIDTH'(FS_RESET_VECTOR),
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = DATA_WIDTH'(FS_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exception,
    input  logic [DATA_WIDTH-1:0] exception_handler_address,
    input  logic [DATA_WIDTH-1:0] cache_in,
    input  logic                  cache_valid,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  branch,
    output logic [DATA_WIDTH-1:0] fetch_address_out,
    output logic [DATA_WIDTH-1:0] instruction_address_out,
    output logic [DATA_WIDTH-1:0] pc_plus_4_out,
    output logic [DATA_WIDTH-1:0] instruction_out,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                  fetch_misaligned_out,
`endif
    output logic                  instruction_valid_out
);

    fetch_act_e            w_act;
    logic [DATA_WIDTH-1:0] w_pc;
    logic [DATA_WIDTH-1:0] r_instr_addr;
    logic [DATA_WIDTH-1:0] r_pc_plus_4;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_valid;

    assign w_act = fetch_action(exception, branch, flush, stall, cache_valid);

    fetch_pc_reg #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk          (clk),
        .reset        (reset),
        .i_act        (w_act),
        .i_exc_target (exception_handler_address),
        .i_br_target  (branch_target),
        .o_pc         (w_pc)
    );

    // IF/ID register: redirects, flushes and misses all insert a bubble; stall holds everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_addr <= '0;
            r_pc_plus_4  <= '0;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
        end else begin
            case (w_act)
                ACT_STALL: ;
                ACT_FETCH: begin
                    r_instr      <= cache_in;
                    r_instr_addr <= w_pc;
                    r_pc_plus_4  <= w_pc + DATA_WIDTH'(4);
                    r_valid      <= 1'b1;
                end
                default: begin
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_misaligned <= 1'b0;
        else        r_misaligned <= ((w_act == ACT_EXC) && (exception_handler_address[1:0] != 2'b00))
                                 || ((w_act == ACT_BR)  && (branch_target[1:0] != 2'b00));
    end

    assign fetch_misaligned_out = r_misaligned;
`endif

    assign fetch_address_out       = w_pc;
    assign instruction_address_out = r_instr_addr;
    assign pc_plus_4_out           = r_pc_plus_4;
    assign instruction_out         = r_instr;
    assign instruction_valid_out   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, exception, branch, cache_valid;
    logic [31:0] exception_handler_address, cache_in, branch_target;
    logic [31:0] fetch_address_out, instruction_address_out, pc_plus_4_out, instruction_out;
    logic        instruction_valid_out;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_ia, m_p4, m_ins;
    logic        m_val, m_mis;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                       (clk),
        .reset                     (reset),
        .stall                     (stall),
        .flush                     (flush),
        .exception                 (exception),
        .exception_handler_address (exception_handler_address),
        .cache_in                  (cache_in),
        .cache_valid               (cache_valid),
        .branch_target             (branch_target),
        .branch                    (branch),
        .fetch_address_out         (fetch_address_out),
        .instruction_address_out   (instruction_address_out),
        .pc_plus_4_out             (pc_plus_4_out),
        .instruction_out           (instruction_out),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_misaligned_out      (fetch_misaligned_out),
`endif
        .instruction_valid_out     (instruction_valid_out)
    );

    function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a & 32'hFFFF_FFFC;
`else
        return a;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ia = 32'h0; m_p4 = 32'h0; m_ins = NOP; m_val = 1'b0; m_mis = 1'b0;
    endtask

    // One clock edge as the pipeline contract describes it.
    task automatic model_edge();
        m_mis = 1'b0;
        if (exception) begin
            m_mis = (exception_handler_address[1:0] != 2'b00);
            m_pc = tgt(exception_handler_address); m_val = 1'b0; m_ins = NOP;
        end else if (branch) begin
            m_mis = (branch_target[1:0] != 2'b00);
            m_pc = tgt(branch_target); m_val = 1'b0; m_ins = NOP;
        end else if (flush) begin
            m_val = 1'b0; m_ins = NOP;
        end else if (stall) begin
            // everything holds
        end else if (cache_valid) begin
            m_ins = cache_in; m_ia = m_pc; m_p4 = m_pc + 32'd4; m_val = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
            m_val = 1'b0; m_ins = NOP;
        end
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; exception = 0; branch = 0; cache_valid = 0;
        exception_handler_address = 0; cache_in = 0; branch_target = 0;
    endtask

    // Advance one edge, update the model, then settle away from the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        #20;
        n_cmp++; if (fetch_address_out !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", fetch_address_out, 32'h0); end
        n_cmp++; if (instruction_out !== NOP) begin n_err++; $display("FAIL reset_instr got=%h exp=%h", instruction_out, NOP); end
        n_cmp++; if (instruction_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", instruction_valid_out); end
        n_cmp++; if ({instruction_address_out, pc_plus_4_out} !== 64'h0) begin n_err++; $display("FAIL reset_addr got=%h/%h exp=0/0", instruction_address_out, pc_plus_4_out); end
    endtask

    task automatic test_first_fetch();
        reset = 1'b1; cache_in = 32'h1; cache_valid = 1'b1;
        cycle();
        n_cmp++; if (instruction_out !== 32'h1) begin n_err++; $display("FAIL first_instr got=%h exp=1", instruction_out); end
        n_cmp++; if (instruction_address_out !== 32'h0 || pc_plus_4_out !== 32'h4) begin n_err++; $display("FAIL first_addr got=%h/%h exp=0/4", instruction_address_out, pc_plus_4_out); end
        n_cmp++; if (instruction_valid_out !== 1'b1 || fetch_address_out !== 32'h4) begin n_err++; $display("FAIL first_pc got=%b/%h exp=1/4", instruction_valid_out, fetch_address_out); end
    endtask

    task automatic test_branch();
        cache_valid = 1'b0; branch = 1'b1; branch_target = 32'h1000;
        cycle();
        branch = 1'b0;
        n_cmp++; if (fetch_address_out !== 32'h1000) begin n_err++; $display("FAIL branch_pc got=%h exp=1000", fetch_address_out); end
        n_cmp++; if (instruction_valid_out !== 1'b0 || instruction_out !== NOP) begin n_err++; $display("FAIL branch_bubble got=%b/%h exp=0/%h", instruction_valid_out, instruction_out, NOP); end
    endtask

    task automatic test_exception_priority();
        exception = 1'b1; exception_handler_address = 32'h2000; branch = 1'b1; branch_target = 32'h3000;
        cache_valid = 1'b1; cache_in = 32'hDEAD_BEEF;
        cycle();
        exception = 1'b0; branch = 1'b0; cache_valid = 1'b0;
        n_cmp++; if (fetch_address_out !== 32'h2000) begin n_err++; $display("FAIL exc_pc got=%h exp=2000", fetch_address_out); end
        n_cmp++; if (instruction_valid_out !== 1'b0 || instruction_out !== NOP) begin n_err++; $display("FAIL exc_bubble got=%b/%h exp=0/%h", instruction_valid_out, instruction_out, NOP); end
    endtask

    task automatic test_flush();
        flush = 1'b1; stall = 1'b1; cache_valid = 1'b1; cache_in = 32'h5;
        cycle();
        flush = 1'b0; stall = 1'b0;
        n_cmp++; if (instruction_valid_out !== 1'b0 || fetch_address_out !== 32'h2000) begin n_err++; $display("FAIL flush got=%b/%h exp=0/2000", instruction_valid_out, fetch_address_out); end
        cache_in = 32'h2;
        cycle();
        n_cmp++; if (instruction_out !== 32'h2 || instruction_valid_out !== 1'b1) begin n_err++; $display("FAIL post_flush_instr got=%h/%b exp=2/1", instruction_out, instruction_valid_out); end
        n_cmp++; if (instruction_address_out !== 32'h2000 || pc_plus_4_out !== 32'h2004) begin n_err++; $display("FAIL post_flush_addr got=%h/%h exp=2000/2004", instruction_address_out, pc_plus_4_out); end
    endtask

    task automatic test_stall();
        stall = 1'b1; cache_valid = 1'b1; cache_in = 32'h20002;
        cycle();
        n_cmp++; if (instruction_out !== 32'h2 || instruction_valid_out !== 1'b1 || fetch_address_out !== 32'h2004) begin
            n_err++; $display("FAIL stall_hold got=%h/%b/%h exp=2/1/2004", instruction_out, instruction_valid_out, fetch_address_out); end
        n_cmp++; if (instruction_address_out !== 32'h2000 || pc_plus_4_out !== 32'h2004) begin n_err++; $display("FAIL stall_addr got=%h/%h exp=2000/2004", instruction_address_out, pc_plus_4_out); end
        stall = 1'b0; cache_valid = 1'b0;
        cycle();
        n_cmp++; if (instruction_valid_out !== 1'b0 || fetch_address_out !== 32'h2004 || instruction_out !== NOP) begin
            n_err++; $display("FAIL miss got=%b/%h/%h exp=0/2004/%h", instruction_valid_out, fetch_address_out, instruction_out, NOP); end
        n_cmp++; if (instruction_address_out !== 32'h2000) begin n_err++; $display("FAIL miss_addr_hold got=%h exp=2000", instruction_address_out); end
    endtask

    task automatic test_wrap();
        branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        cycle();
        branch = 1'b0; cache_valid = 1'b1; cache_in = 32'h0000_0ABC;
        cycle();
        cache_valid = 1'b0;
        n_cmp++; if (instruction_address_out !== 32'hFFFF_FFFC || pc_plus_4_out !== 32'h0) begin n_err++; $display("FAIL wrap_addr got=%h/%h exp=fffffffc/0", instruction_address_out, pc_plus_4_out); end
        n_cmp++; if (fetch_address_out !== 32'h0 || instruction_out !== 32'hABC) begin n_err++; $display("FAIL wrap_pc got=%h/%h exp=0/abc", fetch_address_out, instruction_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            exception   = ($urandom_range(0, 15) == 0);
            branch      = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            cache_valid = ($urandom_range(0, 3) != 0);
            cache_in    = $urandom;
            exception_handler_address = $urandom;
            branch_target = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
`ifndef FETCH_ALIGN_CHECK_EN
            exception_handler_address = exception_handler_address & 32'hFFFF_FFFC;
            branch_target = branch_target & 32'hFFFF_FFFC;
`endif
            cycle();
            n_cmp++;
            if (fetch_address_out !== m_pc || instruction_out !== m_ins || instruction_valid_out !== m_val
                || instruction_address_out !== m_ia || pc_plus_4_out !== m_p4) begin
                n_err++;
                $display("FAIL random[%0d] got pc=%h ins=%h v=%b ia=%h p4=%h exp pc=%h ins=%h v=%b ia=%h p4=%h", i,
                         fetch_address_out, instruction_out, instruction_valid_out, instruction_address_out, pc_plus_4_out,
                         m_pc, m_ins, m_val, m_ia, m_p4);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            n_cmp++; if (fetch_misaligned_out !== m_mis) begin n_err++; $display("FAIL misaligned[%0d] got=%b exp=%b", i, fetch_misaligned_out, m_mis); end
`endif
        end
        clear_inputs();
    endtask

    task automatic test_reset_midstream();
        cache_valid = 1'b1; cache_in = 32'h1234_5678;
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (fetch_address_out !== m_pc || instruction_out !== m_ins || instruction_valid_out !== m_val
                     || instruction_address_out !== m_ia || pc_plus_4_out !== m_p4) begin
            n_err++; $display("FAIL async_reset got pc=%h ins=%h v=%b ia=%h p4=%h exp pc=0 ins=%h v=0 ia=0 p4=0",
                              fetch_address_out, instruction_out, instruction_valid_out, instruction_address_out, pc_plus_4_out, NOP);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_branch();
        test_exception_priority();
        test_flush();
        test_stall();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
